// File: rtl/hqm_system_fifo_ctl_pkg.sv
// Shared sizing constants and data/pointer types for the 32x13 RF FIFO controller.
package hqm_system_fifo_ctl_pkg;

  localparam int DEPTH     = 32;
  localparam int DWIDTH    = 13;
  localparam int AWIDTH    = $clog2(DEPTH);
  localparam int STG_DEPTH = 2;
  localparam int STG_CW    = $clog2(STG_DEPTH + 1);

  typedef logic [DWIDTH-1:0] fifo_data_t;
  typedef logic [AWIDTH-1:0] fifo_ptr_t;

endpackage

// File: rtl/hqm_system_fifo_ctl_stage2.sv
// Two-entry output FIFO that absorbs the RF read latency; accepts a capture and a pop in the same cycle.
module hqm_system_fifo_ctl_stage2
  import hqm_system_fifo_ctl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_v,
  input  fifo_data_t        cap_data,
  output logic              pop_v,
  output fifo_data_t        pop_data,
  input  logic              pop_ready,
  output logic [STG_CW-1:0] stg_cnt
);

  localparam int SPW = $clog2(STG_DEPTH);

  fifo_data_t        r_slot [STG_DEPTH];
  logic [SPW-1:0]    r_head;
  logic [SPW-1:0]    r_tail;
  logic [STG_CW-1:0] r_cnt;
  logic              w_pop;

  assign w_pop = pop_v & pop_ready;

  // Capture is dropped in a reset cycle so a read returning across reset is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      if (cap_v) begin
        r_slot[r_tail] <= cap_data;
        r_tail         <= r_tail + SPW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + SPW'(1);
      end
      r_cnt <= r_cnt + STG_CW'(cap_v) - STG_CW'(w_pop);
    end
  end

  assign pop_v    = (r_cnt != '0);
  assign pop_data = r_slot[r_head];
  assign stg_cnt  = r_cnt;

endmodule

// File: rtl/hqm_system_mem_AW_rf_pg_32x13.sv
// 32x13 register file: one write port and one read port with a registered read (data the cycle after re).
module hqm_system_mem_AW_rf_pg_32x13
  import hqm_system_fifo_ctl_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  fifo_ptr_t  waddr,
  input  fifo_data_t wdata,
  input  logic       re,
  input  fifo_ptr_t  raddr,
  output fifo_data_t rdata
);

  fifo_data_t r_mem [DEPTH];
  fifo_data_t r_rdata;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // The controller never reads the address it is writing in the same cycle.
  always_ff @(posedge clk) begin
    if (re) begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/hqm_system_fifo_ctl_32x13.sv
// FIFO controller for an external 32x13 power-gated RF: push port, RF read issue, 2-entry output stage, status.
module hqm_system_fifo_ctl_32x13 #(
  parameter int DEPTH  = 32,
  parameter int DWIDTH = 13,
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_v,
  input  logic [DWIDTH-1:0] push_data,
  output logic              push_ready,
  output logic              pop_v,
  output logic [DWIDTH-1:0] pop_data,
  input  logic              pop_ready,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_waddr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              mem_re,
  output logic [AWIDTH-1:0] mem_raddr,
  input  logic [DWIDTH-1:0] mem_rdata,
  input  logic              mem_pwr_ok,
  input  logic [5:0]        cfg_hwm,
  output logic [5:0]        depth,
  output logic              hwm_hit,
  output logic              err_pwr_drop
);

  localparam int CW        = $clog2(DEPTH + 1);
  localparam int SW        = hqm_system_fifo_ctl_pkg::STG_CW;
  localparam int STG_DEPTH = hqm_system_fifo_ctl_pkg::STG_DEPTH;

  logic [AWIDTH-1:0] r_wptr;
  logic [AWIDTH-1:0] r_rptr;
  logic [CW-1:0]     r_ram_cnt;
  logic              r_rd_inflight;
  logic [5:0]        r_depth;
  logic              r_hwm_hit;
  logic              r_err_pwr_drop;

  logic              w_full;
  logic              w_ram_empty;
  logic              w_push;
  logic              w_pop;
  logic [SW-1:0]     w_stg_cnt;
  logic [2:0]        w_stg_load;
  logic [CW-1:0]     w_ram_cnt_next;
  logic [5:0]        w_depth_next;

  assign w_full      = (r_ram_cnt == CW'(DEPTH));
  assign w_ram_empty = (r_ram_cnt == '0);

  // Ready depends only on registered state, so a same-cycle read never opens a slot early.
  assign push_ready = ~rst & mem_pwr_ok & ~w_full;
  assign w_push     = push_v & push_ready;
  assign w_pop      = pop_v & pop_ready;

  // Stage occupancy after this edge, counting the capture of any read already in flight.
  assign w_stg_load = 3'(w_stg_cnt) + 3'(r_rd_inflight) - 3'(w_pop);

  assign mem_re    = ~rst & mem_pwr_ok & ~w_ram_empty & (w_stg_load < 3'(STG_DEPTH));
  assign mem_raddr = r_rptr;
  assign mem_we    = w_push;
  assign mem_waddr = r_wptr;
  assign mem_wdata = push_data;

  assign w_ram_cnt_next = r_ram_cnt + CW'(w_push) - CW'(mem_re);
  assign w_depth_next   = 6'(w_ram_cnt_next) + 6'(mem_re) + 6'(w_stg_load);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_ram_cnt      <= '0;
      r_rd_inflight  <= 1'b0;
      r_depth        <= '0;
      r_hwm_hit      <= 1'b0;
      r_err_pwr_drop <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AWIDTH'(1);
      end
      if (mem_re) begin
        r_rptr <= r_rptr + AWIDTH'(1);
      end
      r_ram_cnt      <= w_ram_cnt_next;
      r_rd_inflight  <= mem_re;
      r_depth        <= w_depth_next;
      r_hwm_hit      <= (r_depth >= cfg_hwm);
      r_err_pwr_drop <= r_err_pwr_drop | (~mem_pwr_ok & ~w_ram_empty);
    end
  end

  hqm_system_fifo_ctl_stage2 u_stage (
    .clk       (clk),
    .rst       (rst),
    .cap_v     (r_rd_inflight),
    .cap_data  (mem_rdata),
    .pop_v     (pop_v),
    .pop_data  (pop_data),
    .pop_ready (pop_ready),
    .stg_cnt   (w_stg_cnt)
  );

  assign depth        = r_depth;
  assign hwm_hit      = r_hwm_hit;
  assign err_pwr_drop = r_err_pwr_drop;

endmodule
